// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a 4:1 single-bit mux: owns the select lines and gates the data output.
// Optional per-owner hold limit compiled in with `define ARB_TIMEOUT_EN (MAX_HOLD cycles).
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] w,
  output logic [3:0] grant,
  output logic [1:0] s,
  output logic       busy,
  output logic       y
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux4_rr_arbiter: MAX_HOLD must be in 2..255");
  end

  logic [0:0] r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_owner;
  logic [3:0] r_grant;
  logic [1:0] r_s;

  logic [3:0] w_own_oh;
  logic [3:0] w_others;
  logic       w_release;
  logic       w_timeout;
  logic [1:0] w_ptr_ho;
  logic [1:0] w_pick_idle;
  logic [1:0] w_pick_ho;

  // First set bit of m, scanning circularly upward from base.
  function automatic logic [1:0] pick(input logic [3:0] m, input logic [1:0] base);
    logic [1:0] idx;
    logic       found;
    pick  = base;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!found && m[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign w_own_oh    = 4'b0001 << r_owner;
  assign w_others    = req & ~w_own_oh;
  assign w_release   = (r_state == ST_GRANT) && !req[r_owner];
  assign w_ptr_ho    = r_owner + 2'd1;
  assign w_pick_idle = pick(req, r_ptr);
  assign w_pick_ho   = pick(w_others, w_ptr_ho);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] LP_HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] r_hold_cnt;
  logic       w_at_limit;

  assign w_at_limit = (r_hold_cnt == LP_HOLD_LAST);
  // Preempt only when someone else is waiting; a lone owner just wraps the counter.
  assign w_timeout  = (r_state == ST_GRANT) && req[r_owner] && w_at_limit && (|w_others);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= 8'd0;
    end else if (r_state == ST_IDLE || w_release || w_timeout || w_at_limit) begin
      r_hold_cnt <= 8'd0;
    end else begin
      r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_owner <= 2'd0;
      r_grant <= 4'b0000;
      r_s     <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_owner <= w_pick_idle;
            r_grant <= 4'b0001 << w_pick_idle;
            r_s     <= w_pick_idle;
            r_state <= ST_GRANT;
          end
        end
        default: begin
          if (w_release || w_timeout) begin
            r_ptr <= w_ptr_ho;
            // Direct handoff in the same edge keeps the mux busy with no idle gap.
            if (|w_others) begin
              r_owner <= w_pick_ho;
              r_grant <= 4'b0001 << w_pick_ho;
              r_s     <= w_pick_ho;
            end else begin
              r_grant <= 4'b0000;
              r_state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign s     = r_s;
  assign busy  = |r_grant;
  assign y     = busy & w[r_s];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: vector table plus timeout / single-requester sequences.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] w;
  logic [3:0] grant;
  logic [1:0] s;
  logic       busy;
  logic       y;

  int checks   = 0;
  int failures = 0;

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .w     (w),
    .grant (grant),
    .s     (s),
    .busy  (busy),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] w;
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    logic       y;
    string      name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] wd,
                              input logic [3:0] g, input logic [1:0] sx, input logic b,
                              input logic yy, input string nm);
    vec_t v;
    v.rst = r; v.req = rq; v.w = wd; v.g = g; v.s = sx; v.b = b; v.y = yy; v.name = nm;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [3:0] eg, input logic [1:0] es,
                       input logic eb, input logic ey);
    checks++;
    if (grant !== eg || s !== es || busy !== eb || y !== ey) begin
      failures++;
      $display("FAIL %s: got grant=%b s=%0d busy=%b y=%b, want grant=%b s=%0d busy=%b y=%b",
               nm, grant, s, busy, y, eg, es, eb, ey);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    w   = 4'b0000;

    //             rst   req      w        grant    s  busy y
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, "reset0"));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, "reset1"));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0, "idle"));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 0, 1, 1, "first_grant"));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 0, 1, 0, "y_follows_w"));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 0, 1, 0, "no_preempt"));
    tbl.push_back(mk(0, 4'b1110, 4'b0010, 4'b0010, 1, 1, 1, "rot_1"));
    tbl.push_back(mk(0, 4'b1101, 4'b0000, 4'b0100, 2, 1, 0, "rot_2"));
    tbl.push_back(mk(0, 4'b1011, 4'b1000, 4'b1000, 3, 1, 1, "rot_3"));
    tbl.push_back(mk(0, 4'b0111, 4'b0001, 4'b0001, 0, 1, 1, "rot_wrap_0"));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 0, 1, 0, "hold_0"));
    tbl.push_back(mk(0, 4'b1110, 4'b0000, 4'b0010, 1, 1, 0, "handoff_1"));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 1, 0, 0, "release_idle"));
    tbl.push_back(mk(0, 4'b1011, 4'b1000, 4'b1000, 3, 1, 1, "prio_ptr2"));
    tbl.push_back(mk(0, 4'b1011, 4'b0000, 4'b1000, 3, 1, 0, "prio_hold"));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 4'b0100, 2, 1, 1, "to_owner2"));
    tbl.push_back(mk(0, 4'b1111, 4'b0100, 4'b0100, 2, 1, 1, "owner2_hold"));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0, "mid_reset"));
    tbl.push_back(mk(0, 4'b1111, 4'b0001, 4'b0001, 0, 1, 1, "after_reset_ptr0"));

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      req = tbl[i].req;
      w   = tbl[i].w;
      tick();
      check(tbl[i].name, tbl[i].g, tbl[i].s, tbl[i].b, tbl[i].y);
    end

    // Two competing requesters held continuously.
    rst = 1'b1; req = 4'b0000; w = 4'b0011;
    tick();
    rst = 1'b0; req = 4'b0011;
    for (int k = 0; k < 16; k++) begin
      logic [3:0] eg;
      logic [1:0] es;
`ifdef ARB_TIMEOUT_EN
      eg = (((k / 4) % 2) == 0) ? 4'b0001 : 4'b0010;
`else
      eg = 4'b0001;
`endif
      es = (eg == 4'b0010) ? 2'd1 : 2'd0;
      tick();
      check($sformatf("two_req_cycle%0d", k), eg, es, 1'b1, 1'b1);
    end

    // Lone requester never loses the grant.
    rst = 1'b1; req = 4'b0000; w = 4'b0100;
    tick();
    rst = 1'b0; req = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("single_req_cycle%0d", k), 4'b0100, 2'd2, 1'b1, 1'b1);
    end

    req = 4'b0000;
    tick();
    check("single_release", 4'b0000, 2'd2, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer for the 4:1 single-bit multiplexer datapath. Four requesters compete for the shared mux output. The block grants one requester at a time, drives the registered 2-bit select, and presents the selected data bit gated by the grant state. It sits directly in front of the 4:1 mux and owns its select lines, so no other logic drives `s`.

## Interface

Parameters:
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per owner when the timeout feature is compiled in; legal range 2..255.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  4  request lines; bit i is requester i, level-sensitive.
- `w`    input  4  mux data inputs; bit i is the data of requester i.
- `grant`  output  4  registered one-hot grant, or all zero when idle.
- `s`    output  2  registered mux select: binary index of the current or last owner.
- `busy`  output  1  high while any grant is active; equals `|grant`.
- `y`    output  1  `w[s]` when `busy`, else 0 (combinational from `w`).

## Operation

- Internal state:
  - `state` ∈ {IDLE, GRANT}
  - `ptr[1:0]`: highest-priority index for the next arbitration
  - `owner[1:0]`
  - `hold_cnt` (8 bits)
- Selection function `pick(mask)`: the first set bit of `req & mask`, scanning circularly from `ptr` (ptr, ptr+1, ptr+2, ptr+3, mod 4).
- **IDLE:**
  - If `req != 0`: owner ← pick(4'b1111); grant ← onehot(owner); s ← owner; hold_cnt ← 0; go to GRANT.
  - Otherwise stay in IDLE; `s` keeps its last value.
- **GRANT, owner's request still high:**
  - Grant is held; hold_cnt increments (timeout feature only).
- **GRANT, `req[owner]` low at an edge (release):**
  - ptr ← owner+1.
  - If another request is pending (`req & ~onehot(owner) != 0`), hand off directly in the same edge: new owner = pick over the remaining requests with ptr = old owner+1. There is no idle cycle.
  - Otherwise: grant ← 0, busy ← 0, go to IDLE.
- Wrap-around: after owner 3, ptr = 0.
- Requests arriving while another requester holds the grant wait; there is no preemption except by timeout.
- A single requester with no competition holds the grant indefinitely.

## Timing

- Reset values (after a `rst` edge): grant = 0, s = 0, busy = 0, y = 0, ptr = 0, state = IDLE, hold_cnt = 0.
- `rst` mid-grant clears everything at that edge, regardless of `req`.
- Grant latency: `req` sampled high at edge N → `grant`, `s` and `busy` valid after edge N (one cycle).
- Release latency: `req[owner]` sampled low at edge N → old grant deasserted after edge N; the next owner, if any, is granted at that same edge.
- Simultaneous requests in IDLE: the lowest circular distance from `ptr` wins. Example: ptr = 2 with req = 4'b1011 → owner 3.
- `y` follows `w` combinationally with no added latency; only `s` and `busy` are registered.

## Configuration

- Macro `ARB_TIMEOUT_EN`.
- **Defined:**
  - In GRANT, hold_cnt increments each cycle the owner keeps the grant.
  - When hold_cnt == MAX_HOLD-1 and another request is pending, the block forces a handoff at that edge, exactly as on a release (ptr ← owner+1, pick among the others).
  - The preempted requester re-competes normally.
  - If no other request is pending at the limit, hold_cnt resets to 0 and the grant is kept.
  - hold_cnt resets to 0 on every new grant.
- **Not defined:**
  - No counter logic.
  - The grant is held until the owner drops its request.

## Test plan

- Reset and idle: `rst` = 1 for 2 cycles, req = 0 → grant = 0, s = 0, busy = 0, y = 0. Then req = 4'b0001, w = 4'b0001 → one cycle later grant = 4'b0001, s = 0, y = 1.
- Rotation: hold req = 4'b1111 and have each owner drop its request for one cycle on the cycle after it is granted → owner sequence 0,1,2,3,0 with s = 0,1,2,3,0, and no idle gap between grants.
- Priority after release: ptr = 2 (owner 1 just released), req = 4'b1011 → grant = 4'b1000, s = 3. With w = 4'b1000, y = 1.
- Reset mid-operation: owner 2 active, assert `rst` for 1 cycle with req = 4'b1111 held → grant = 0 after the edge. Next edge → grant = 4'b0001 (ptr reset to 0).
- Timeout (`ARB_TIMEOUT_EN`, MAX_HOLD = 4): req = 4'b0011 held → grant 4'b0001 for 4 cycles, then 4'b0010 for 4 cycles, alternating. Without the macro, grant stays 4'b0001 indefinitely.
- Single requester with timeout: req = 4'b0100 held for 20 cycles → grant stays 4'b0100 continuously with no dropouts.
